mux_sequencer: RTL and testbench

//  Parametrised LED multiplexing sequencer; successor of the fixed 8-way mux driver.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_sequencer.sv | 126 ++++++++++++
 tb/tb_mux_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and limits for the LED row multiplexing sequencer.
package mux_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} mux_state_t;

  localparam int CLK_PERIOD_NS    = 20;
  // 500 cycles at 50 MHz = 10 us, the longest a row MOSFET may be held on.
  localparam int MAX_DRIVE_CYCLES = 500;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mux_sequencer.sv
// Steps a one-hot row select across N_MUX rows: an all-off BLANK gap, then a
// bounded DRIVE window per row, with strobes so row data can latch during BLANK.
module mux_sequencer
  import mux_pkg::*;
#(
  parameter int N_MUX        = 8,
  parameter int DRIVE_CYCLES = 500,
  parameter int BLANK_CYCLES = 25,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                     clk_50,
  input  logic                     nrst,
  input  logic                     enable,
  input  logic                     frame_sync,
  output logic [N_MUX-1:0]         mux_out,
  output logic [$clog2(N_MUX)-1:0] mux_idx,
  output logic                     row_strobe,
  output logic                     frame_start,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_MUX);
  localparam int CNT_W = $clog2(max2(DRIVE_CYCLES, BLANK_CYCLES) + 1);

  // Counters run down to zero, so a window of L cycles reloads with L-1.
  // A zero-length blank still occupies one all-off cycle.
  localparam logic [CNT_W-1:0] DRIVE_LD = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MUX - 1);
  localparam logic [N_MUX-1:0] INACTIVE = {N_MUX{ACTIVE_LOW}};

  if (DRIVE_CYCLES > MAX_DRIVE_CYCLES || DRIVE_CYCLES == 0 || N_MUX < 2) begin : g_param_check
    $fatal(1, "mux_sequencer: illegal parameters (DRIVE_CYCLES=%0d N_MUX=%0d)",
           DRIVE_CYCLES, N_MUX);
  end

  mux_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_MUX-1:0] mux_out_q, mux_out_d;
  logic             row_strobe_q, row_strobe_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             restart;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    row_strobe_d  = 1'b0;
    frame_start_d = 1'b0;
    // frame_sync only matters once running; a start from IDLE is the same restart.
    restart       = enable && ((state_q == IDLE) || frame_sync);

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (restart) begin
      state_d       = BLANK;
      cnt_d         = BLANK_LD;
      idx_d         = '0;
      row_strobe_d  = 1'b1;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = DRIVE;
            cnt_d   = DRIVE_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_d       = BLANK;
            cnt_d         = BLANK_LD;
            idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            row_strobe_d  = 1'b1;
            frame_start_d = (idx_q == LAST_IDX);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with it after the edge.
    mux_out_d = INACTIVE;
    if (state_d == DRIVE) mux_out_d = (N_MUX'(1) << idx_d) ^ INACTIVE;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50 or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      mux_out_q     <= INACTIVE;
      row_strobe_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      mux_out_q     <= mux_out_d;
      row_strobe_q  <= row_strobe_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign mux_out     = mux_out_q;
  assign mux_idx     = idx_q;
  assign row_strobe  = row_strobe_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Bench for mux_sequencer: a default instance and a 4-row, no-blank, active-low
// instance share one stimulus stream and are checked against a cycle-count model.
module tb_mux_sequencer;

  localparam int DRIVE = 500;

  // Handshake: the model pushes one expected word per clock edge taken out of
  // reset; the monitor pops exactly one word on the following falling edge.
  logic clk_50 = 1'b0;
  logic nrst, enable, frame_sync;

  logic [7:0] mux_a;
  logic [2:0] idx_a;
  logic       rs_a, fs_a, busy_a;
  logic [3:0] mux_b;
  logic [1:0] idx_b;
  logic       rs_b, fs_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #10 clk_50 = ~clk_50;

  mux_sequencer #(.N_MUX(8), .DRIVE_CYCLES(DRIVE), .BLANK_CYCLES(25), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk_50(clk_50), .nrst(nrst), .enable(enable), .frame_sync(frame_sync),
    .mux_out(mux_a), .mux_idx(idx_a), .row_strobe(rs_a), .frame_start(fs_a), .busy(busy_a)
  );

  mux_sequencer #(.N_MUX(4), .DRIVE_CYCLES(DRIVE), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk_50(clk_50), .nrst(nrst), .enable(enable), .frame_sync(frame_sync),
    .mux_out(mux_b), .mux_idx(idx_b), .row_strobe(rs_b), .frame_start(fs_b), .busy(busy_b)
  );

  // Expected outputs from k = cycles since the last (re)start:
  // bits [7:0] mux, [11:8] idx, 12 row_strobe, 13 frame_start, 14 busy.
  function automatic logic [15:0] model_out(input int n, input int blank, input int drive,
                                            input bit al, input bit run, input int k);
    logic [15:0] r;
    logic [7:0]  m;
    int beff, per, row, off;
    r = '0;
    m = al ? 8'((1 << n) - 1) : 8'h00;
    if (run) begin
      beff = (blank == 0) ? 1 : blank;
      per  = beff + drive;
      row  = (k / per) % n;
      off  = k % per;
      if (off >= beff) m = m ^ 8'(1 << row);
      r[11:8] = 4'(row);
      r[12]   = (off == 0);
      r[13]   = (off == 0) && (row == 0);
      r[14]   = 1'b1;
    end
    r[7:0] = m;
    return r;
  endfunction

  // Reference model
  logic [31:0] exp_q[$];
  bit run = 1'b0;
  int k = 0;

  always @(posedge clk_50) begin
    if (!nrst) begin
      run = 1'b0;
      k   = 0;
    end else begin
      if (!enable) run = 1'b0;
      else if (!run) begin run = 1'b1; k = 0; end
      else if (frame_sync) k = 0;
      else k++;
      exp_q.push_back({model_out(4, 0, DRIVE, 1'b1, run, k),
                       model_out(8, 25, DRIVE, 1'b0, run, k)});
    end
  end

  // Monitor / scoreboard
  int cyc = 0;
  int strobe_cnt_a = 0, fs_cnt_a = 0, strobe_cnt_b = 0, fs_cnt_b = 0;
  int prev_fs_a = 0, last_fs_a = 0;
  int run_len_a = 0, run_len_b = 0;
  logic [7:0]  prev_a = '0;
  logic [3:0]  prev_b = '0;
  logic [3:0]  hi_b;
  logic [31:0] e;
  logic [15:0] act_a, act_b;

  always @(negedge clk_50) begin
    cyc++;
    act_a = {1'b0, busy_a, fs_a, rs_a, 1'b0, idx_a, mux_a};
    act_b = {1'b0, busy_b, fs_b, rs_b, 2'b00, idx_b, 4'h0, mux_b};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_a !== e[15:0]) begin
        errors++;
        $display("FAIL model_a cyc %0d: got %h want %h (busy,fs,rs,idx,mux)", cyc, act_a, e[15:0]);
      end
      checks++;
      if (act_b !== e[31:16]) begin
        errors++;
        $display("FAIL model_b cyc %0d: got %h want %h (busy,fs,rs,idx,mux)", cyc, act_b, e[31:16]);
      end
    end

    hi_b = ~mux_b;
    checks++;
    if (!$onehot0(mux_a) || !$onehot0(hi_b)) begin
      errors++;
      $display("FAIL onehot cyc %0d: got a=%h b_active=%h want at most one active", cyc, mux_a, hi_b);
    end

    if (mux_a == 8'h00) run_len_a = 0;
    else if (mux_a == prev_a) run_len_a++;
    else run_len_a = 1;
    if (hi_b == 4'h0) run_len_b = 0;
    else if (hi_b == prev_b) run_len_b++;
    else run_len_b = 1;
    prev_a = mux_a;
    prev_b = hi_b;
    checks++;
    if (run_len_a > DRIVE || run_len_b > DRIVE) begin
      errors++;
      $display("FAIL drive_len cyc %0d: got a=%0d b=%0d want <= %0d", cyc, run_len_a, run_len_b, DRIVE);
    end

    if (rs_a) strobe_cnt_a++;
    if (rs_b) strobe_cnt_b++;
    if (fs_b) fs_cnt_b++;
    if (fs_a) begin
      fs_cnt_a++;
      prev_fs_a = last_fs_a;
      last_fs_a = cyc;
    end
  end

  // Driver tasks
  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_mux_a(input logic [7:0] v, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk_50);
      if (mux_a == v) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_mux_a: got %h want %h within %0d cycles", mux_a, v, budget);
    end
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    @(posedge clk_50); #1;
    frame_sync = 1'b0;
  endtask

  int s_a, f_a, s_b, f_b;

  initial begin
    nrst = 1'b0; enable = 1'b0; frame_sync = 1'b0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50); #1;
    check_eq("reset_a", int'({busy_a, fs_a, rs_a, idx_a, mux_a}), 0);
    check_eq("reset_b", int'({busy_b, fs_b, rs_b, idx_b, mux_b}), 'h00F);

    @(posedge clk_50); #1 nrst = 1'b1;
    repeat (5) @(posedge clk_50); #1;

    // Two full frames from enable
    s_a = strobe_cnt_a; f_a = fs_cnt_a; s_b = strobe_cnt_b; f_b = fs_cnt_b;
    enable = 1'b1;
    repeat (8400) @(posedge clk_50);
    @(negedge clk_50); #1;
    check_eq("strobes_a_2frames", strobe_cnt_a - s_a, 16);
    check_eq("frames_a_2frames", fs_cnt_a - f_a, 2);
    check_eq("strobes_b_8400", strobe_cnt_b - s_b, 17);
    check_eq("frames_b_8400", fs_cnt_b - f_b, 5);
    check_eq("frame_period_a", last_fs_a - prev_fs_a, 4200);

    // frame_sync in the middle of row 5's drive window
    wait_mux_a(8'h20, 5000);
    @(posedge clk_50);
    repeat (37) @(posedge clk_50); #1;
    pulse_sync();
    repeat (40) @(posedge clk_50); #1;

    // frame_sync sampled at the end of row 7's last drive cycle
    wait_mux_a(8'h80, 5000);
    repeat (499) @(posedge clk_50); #1;
    s_a = strobe_cnt_a; f_a = fs_cnt_a;
    pulse_sync();
    repeat (523) @(posedge clk_50);
    @(negedge clk_50); #1;
    check_eq("wrap_sync_strobes", strobe_cnt_a - s_a, 1);
    check_eq("wrap_sync_frames", fs_cnt_a - f_a, 1);

    // enable dropped mid-drive of row 3
    wait_mux_a(8'h08, 5000);
    repeat (100) @(posedge clk_50); #1;
    enable = 1'b0;
    @(posedge clk_50);
    @(negedge clk_50); #1;
    check_eq("enable_drop_off", int'({busy_a, mux_a}), 0);
    @(posedge clk_50); #1 enable = 1'b1;
    repeat (600) @(posedge clk_50); #1;

    // enable falling together with frame_sync
    enable = 1'b0; frame_sync = 1'b1;
    @(posedge clk_50); #1 frame_sync = 1'b0;
    repeat (3) @(posedge clk_50); #1 enable = 1'b1;

    // asynchronous reset while row 0 drives
    wait_mux_a(8'h01, 500);
    #2 nrst = 1'b0;
    #1;
    check_eq("async_reset_a", int'({busy_a, mux_a}), 0);
    check_eq("async_reset_b", int'(mux_b), 'hF);
    repeat (2) @(posedge clk_50); #1 nrst = 1'b1;

    // Randomized sync pulses and enable drops
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 1500)) @(posedge clk_50); #1;
      case ($urandom_range(0, 2))
        0: pulse_sync();
        1: begin
          enable = 1'b0;
          repeat ($urandom_range(1, 5)) @(posedge clk_50); #1;
          enable = 1'b1;
        end
        default: begin
          enable = 1'b0; frame_sync = 1'b1;
          @(posedge clk_50); #1 frame_sync = 1'b0;
          enable = 1'b1;
        end
      endcase
    end

    repeat (1100) @(posedge clk_50);
    @(negedge clk_50); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
